// File: rtl/ir_key_pkg.sv
// ir_key_pkg: shared encodings and field widths for the IR key controller.
// Holds the FSM state encoding, the event type codes, the SIRC field widths
// and a clog2 helper used to size the frame-gap counter.
package ir_key_pkg;

  localparam int CMD_W   = 7;
  localparam int ADDR_W  = 5;
  localparam int FRAME_W = CMD_W + ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONFIRM = 2'd1,
    S_HELD    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    EV_NONE    = 2'b00,
    EV_PRESS   = 2'b01,
    EV_REPEAT  = 2'b10,
    EV_RELEASE = 2'b11
  } ev_type_e;

  // Number of bits needed to count from 0 to value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ir_frame_decode.sv
// ir_frame_decode: combinational unpacking of one raw receiver frame.
// The receiver shifts bits in so the first bit received lands in [11];
// SIRC sends command then address, each LSB first, so both fields come out
// bit-reversed and are flipped back here before the address compare.
module ir_frame_decode
  import ir_key_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DEVICE_ADDR = 5'd1
) (
  input  logic [FRAME_W-1:0] frame,
  output logic [CMD_W-1:0]   cmd,
  output logic               match_addr
);

  logic [ADDR_W-1:0] addr;

  // Undo the shift-register bit order and compare the address field.
  always_comb begin
    cmd  = '0;
    addr = '0;
    for (int i = 0; i < CMD_W; i++) begin
      cmd[i] = frame[FRAME_W-1-i];
    end
    for (int j = 0; j < ADDR_W; j++) begin
      addr[j] = frame[ADDR_W-1-j];
    end
    match_addr = (addr == DEVICE_ADDR);
  end

endmodule

// File: rtl/ir_key_controller.sv
// ir_key_controller: turns the IR receiver frame stream into debounced
// press / auto-repeat / release events on a single-entry valid/ready port.
// Optional feature macro: IR_AUTOREPEAT_EN enables repeat events while a key
// is held; without it a held key yields exactly one press and one release.
module ir_key_controller
  import ir_key_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DEVICE_ADDR     = 5'd1,
  parameter int                CONFIRM_FRAMES  = 2,
  parameter int                RELEASE_TIMEOUT = 6750000,
  parameter int                REPEAT_FRAMES   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame,
  input  logic               frame_rdy,
  output logic [CMD_W-1:0]   key_code,
  output logic               key_valid,
  output logic               ev_valid,
  output logic [1:0]         ev_type,
  output logic [CMD_W-1:0]   ev_code,
  input  logic               ev_ready,
  output logic               ev_overflow
);

  localparam int               GAP_W      = clog2(RELEASE_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_MAX    = GAP_W'(RELEASE_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_EXPIRE = GAP_W'(RELEASE_TIMEOUT - 1);
  localparam logic [3:0]       CONFIRM_N  = 4'(CONFIRM_FRAMES);
`ifdef IR_AUTOREPEAT_EN
  localparam logic [3:0]       REPEAT_N   = 4'(REPEAT_FRAMES);
`endif

  if (CONFIRM_FRAMES < 1 || CONFIRM_FRAMES > 15) begin : g_bad_confirm
    $error("CONFIRM_FRAMES must be in 1..15");
  end
  if (REPEAT_FRAMES < 1 || REPEAT_FRAMES > 15) begin : g_bad_repeat
    $error("REPEAT_FRAMES must be in 1..15");
  end

  state_e            state_q, state_d;
  logic              frame_rdy_q;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [CMD_W-1:0]  cand_q, cand_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [CMD_W-1:0]  key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
`ifdef IR_AUTOREPEAT_EN
  logic [3:0]        rcnt_q, rcnt_d;
`endif
  logic              ev_valid_q, ev_valid_d;
  ev_type_e          ev_type_q, ev_type_d;
  logic [CMD_W-1:0]  ev_code_q, ev_code_d;
  logic              ev_overflow_q, ev_overflow_d;

  logic              fstb;
  logic              accepted;
  logic              timeout;
  logic [CMD_W-1:0]  cmd;
  logic              match_addr;
  logic              new_ev;
  ev_type_e          new_ev_type;
  logic [CMD_W-1:0]  new_ev_code;
  logic              extra_ev;
  logic              slot_free;

  ir_frame_decode #(
    .DEVICE_ADDR(DEVICE_ADDR)
  ) u_decode (
    .frame     (frame),
    .cmd       (cmd),
    .match_addr(match_addr)
  );

  // Frame strobe, address filter and the gap counter that measures silence.
  always_comb begin
    fstb     = frame_rdy && !frame_rdy_q;
    accepted = fstb && match_addr;
    timeout  = !accepted && (gap_q == GAP_EXPIRE);
    gap_d    = gap_q;
    if (accepted) begin
      gap_d = '0;
    end else if (gap_q != GAP_MAX) begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

  // Key state machine: confirm identical frames, track the held key, raise events.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
`ifdef IR_AUTOREPEAT_EN
    rcnt_d      = rcnt_q;
`endif
    new_ev      = 1'b0;
    new_ev_type = EV_NONE;
    new_ev_code = '0;
    extra_ev    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accepted) begin
          cand_d = cmd;
          cnt_d  = 4'd1;
          if (CONFIRM_N == 4'd1) begin
            state_d     = S_HELD;
            key_code_d  = cmd;
            key_valid_d = 1'b1;
            new_ev      = 1'b1;
            new_ev_type = EV_PRESS;
            new_ev_code = cmd;
`ifdef IR_AUTOREPEAT_EN
            rcnt_d      = 4'd0;
`endif
          end else begin
            state_d = S_CONFIRM;
          end
        end
      end
      S_CONFIRM: begin
        if (accepted) begin
          if (cmd == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == CONFIRM_N) begin
              state_d     = S_HELD;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              new_ev      = 1'b1;
              new_ev_type = EV_PRESS;
              new_ev_code = cand_q;
`ifdef IR_AUTOREPEAT_EN
              rcnt_d      = 4'd0;
`endif
            end
          end else begin
            cand_d = cmd;
            cnt_d  = 4'd1;
          end
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_HELD: begin
        if (accepted) begin
          if (cmd != key_code_q) begin
            new_ev      = 1'b1;
            new_ev_type = EV_RELEASE;
            new_ev_code = key_code_q;
            key_valid_d = 1'b0;
            cand_d      = cmd;
            cnt_d       = 4'd1;
            if (CONFIRM_N == 4'd1) begin
              state_d     = S_HELD;
              key_code_d  = cmd;
              key_valid_d = 1'b1;
              extra_ev    = 1'b1;
`ifdef IR_AUTOREPEAT_EN
              rcnt_d      = 4'd0;
`endif
            end else begin
              state_d = S_CONFIRM;
            end
          end
`ifdef IR_AUTOREPEAT_EN
          else begin
            if (rcnt_q + 4'd1 == REPEAT_N) begin
              rcnt_d      = 4'd0;
              new_ev      = 1'b1;
              new_ev_type = EV_REPEAT;
              new_ev_code = key_code_q;
            end else begin
              rcnt_d = rcnt_q + 4'd1;
            end
          end
`endif
        end else if (timeout) begin
          new_ev      = 1'b1;
          new_ev_type = EV_RELEASE;
          new_ev_code = key_code_q;
          key_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Single-entry event slot: load when free, otherwise drop and flag overflow.
  always_comb begin
    ev_valid_d    = ev_valid_q;
    ev_type_d     = ev_type_q;
    ev_code_d     = ev_code_q;
    ev_overflow_d = ev_overflow_q;
    slot_free     = !ev_valid_q || ev_ready;
    if (new_ev && slot_free) begin
      ev_valid_d = 1'b1;
      ev_type_d  = new_ev_type;
      ev_code_d  = new_ev_code;
    end else if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end
    if ((new_ev && !slot_free) || extra_ev) begin
      ev_overflow_d = 1'b1;
    end
  end

  // State, counters and the event slot; reset discards any held key silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      frame_rdy_q   <= 1'b0;
      gap_q         <= '0;
      cand_q        <= '0;
      cnt_q         <= 4'd0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
`ifdef IR_AUTOREPEAT_EN
      rcnt_q        <= 4'd0;
`endif
      ev_valid_q    <= 1'b0;
      ev_type_q     <= EV_NONE;
      ev_code_q     <= '0;
      ev_overflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_rdy_q   <= frame_rdy;
      gap_q         <= gap_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
`ifdef IR_AUTOREPEAT_EN
      rcnt_q        <= rcnt_d;
`endif
      ev_valid_q    <= ev_valid_d;
      ev_type_q     <= ev_type_d;
      ev_code_q     <= ev_code_d;
      ev_overflow_q <= ev_overflow_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign ev_valid    = ev_valid_q;
  assign ev_type     = ev_type_q;
  assign ev_code     = ev_code_q;
  assign ev_overflow = ev_overflow_q;

endmodule

// File: doc/ir_key_controller.md
Name: ir_key_controller

Overview:
- Sits downstream of the IR frame receiver. Turns its raw 12-bit frame stream into debounced key events: press, auto-repeat and release.
- Reverses the receiver's bit order, filters frames by device address, and confirms a key only after N identical consecutive frames.
- Detects release by frame-gap timeout and delivers events over a single-entry valid/ready output.

Parameters:
- DEVICE_ADDR, 5'd1, accepted device address; frames with any other address are ignored.
- CONFIRM_FRAMES, 2, number of identical consecutive frames needed before a press is emitted (range 1..15).
- RELEASE_TIMEOUT, 6750000, clocks without a matching frame before release (about 3 frame periods at 50 MHz).
- REPEAT_FRAMES, 5, matching frames per auto-repeat event while a key is held (range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- frame  in  12  receiver shift register; first received bit is in [11]
- frame_rdy  in  1  receiver ready level; a complete frame is marked by its rising edge
- key_code  out  7  command of the currently held key
- key_valid  out  1  high while a key is in the HELD state
- ev_valid  out  1  an event is pending
- ev_type  out  2  event kind: 01 press, 10 repeat, 11 release
- ev_code  out  7  command the event refers to
- ev_ready  in  1  consumer accepts the event when ev_valid && ev_ready
- ev_overflow  out  1  sticky; an event was dropped

Behaviour:
- Reset (async): state IDLE; all counters 0; frame_rdy_q 0; all outputs 0. No release event is generated for a key held at reset.
- Frame strobe: fstb = frame_rdy && !frame_rdy_q, registered. Decode in the same cycle fstb is high:
  - cmd[i] = frame[11-i] for i = 0..6
  - addr[j] = frame[4-j] for j = 0..4
  - match_addr = (addr == DEVICE_ADDR)
  - A frame with a non-matching address is discarded completely; it does not reset the timeout.
- gap counter: counts clocks since the last accepted frame; cleared on every accepted frame; saturates at RELEASE_TIMEOUT. timeout = (gap == RELEASE_TIMEOUT-1) && !accepted frame this cycle, so a frame arriving in the expiry cycle wins.
- IDLE:
  - Accepted frame -> cand = cmd, cnt = 1.
  - If CONFIRM_FRAMES == 1, go directly to HELD and emit press(cmd). Otherwise go to CONFIRM.
- CONFIRM:
  - Accepted frame with cmd == cand -> cnt+1. When cnt+1 == CONFIRM_FRAMES: go to HELD, key_code = cand, key_valid = 1, emit press(cand), rcnt = 0.
  - Accepted frame with cmd != cand -> cand = cmd, cnt = 1; stay in CONFIRM.
  - Timeout -> IDLE; no event.
- HELD:
  - Accepted frame with cmd == key_code -> rcnt+1. When rcnt+1 == REPEAT_FRAMES: rcnt = 0 and emit repeat(key_code), only when IR_AUTOREPEAT_EN is defined.
  - Accepted frame with cmd != key_code -> emit release(old key_code), key_valid = 0, cand = cmd, cnt = 1, go to CONFIRM (or straight to HELD plus a press if CONFIRM_FRAMES == 1; the press is then lost to overflow, see below).
  - Timeout -> emit release(key_code), key_valid = 0, go to IDLE.
- Event register:
  - Event is loaded if !ev_valid || ev_ready in that cycle. Otherwise the new event is dropped and ev_overflow is set (cleared only by rst).
  - ev_valid clears on handshake when no new event is loaded that cycle.
  - Latency: fstb cycle -> ev_valid high on the next clock edge.
  - ev_type and ev_code are held stable while ev_valid && !ev_ready.
- Width: gap counter is clog2(RELEASE_TIMEOUT+1) bits; cnt and rcnt are 4 bits.

Optional Feature:
- IR_AUTOREPEAT_EN defined: repeat events are generated as described in HELD.
- Not defined: rcnt logic and the repeat encoding are removed. A held key produces exactly one press and one release, and ev_type never equals 10.

Decomposition:
- Package/header ir_key_pkg.vh holds:
  - state encodings S_IDLE, S_CONFIRM, S_HELD
  - event codes EV_PRESS, EV_REPEAT, EV_RELEASE
  - SIRC field widths CMD_W=7, ADDR_W=5
- Reuse the existing clog2 function include.
- One sub-module: ir_frame_decode, purely combinational. Performs the bit reversal, produces cmd/addr, and computes match_addr.

Test Plan:
- Addr 1, cmd 0x15: frame = 12'b101010_010000 sent twice, 2.25M cycles apart -> one press with ev_code 0x15 one cycle after the second fstb; key_valid = 1.
- Then stop frames -> release(0x15) exactly RELEASE_TIMEOUT cycles after the last accepted frame; key_valid = 0.
- Addr 2 frames interleaved with addr 1 frames -> addr 2 frames produce no events and do not extend the timeout.
- Hold 0x15 for 12 frames with IR_AUTOREPEAT_EN -> press, then repeat after frames 7 and 12; without the macro -> press only.
- While held, switch to cmd 0x20 -> release(0x15), then press(0x20) after two 0x20 frames.
- ev_ready held 0 across press and release -> first event stays stable, ev_overflow = 1.
- Assert rst while HELD -> all outputs 0 immediately, no release event.
